data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU MEM stage and a DMA/loader master.
//  Sits between EX/MEM (CPU address, write data, MemRead, MemWrite) and the data RAM.
//  Grants one master per cycle. CPU has priority, with a bounded-starvation guarantee for DMA.
//  Raises cpu_stall toward the hazard logic whenever the CPU access is not granted.
// PARAMETERS
//  ADDR_W    32  address width, byte address
//  DATA_W    32  data width
//  MAX_WAIT  4   max consecutive contended cycles DMA waits before it is forced a grant (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       asynchronous, active-low; clears all state
//  cpu_req     in   1       CPU access request (MemRead|MemWrite of MEM stage)
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       CPU access performed this cycle
//  cpu_stall   out  1       cpu_req & ~cpu_gnt; freezes PC/IF/ID/EX, bubbles MEM/WB
//  cpu_rvalid  out  1       CPU read data valid (cycle after granted read)
//  cpu_rdata   out  DATA_W  CPU read data; 0 when cpu_rvalid=0
//  dma_req     in   1       DMA access request
//  dma_we      in   1       1=write, 0=read
//  dma_addr    in   ADDR_W  DMA address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_gnt     out  1       DMA access performed this cycle
//  dma_rvalid  out  1       DMA read data valid (cycle after granted read)
//  dma_rdata   out  DATA_W  DMA read data; 0 when dma_rvalid=0
//  mem_rd      out  1       RAM read strobe
//  mem_wr      out  1       RAM write strobe
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, valid one cycle after mem_rd
// BEHAVIOUR
//  Reset (reset=0, async):
//   - owner FSM=IDLE, wait_cnt=0, rd_owner=NONE.
//   - All gnt/rvalid/stall/mem strobes=0; rdata=0, mem_addr=0, mem_wdata=0.
//   - An in-flight read return is dropped and never delivered.
//  Grant (combinational from reqs + registered state):
//   - Exactly 0 or 1 of cpu_gnt/dma_gnt per cycle.
//   - Only one master requesting: that master is granted (0-cycle arbitration latency).
//   - Both requesting: dma_gnt if wait_cnt==MAX_WAIT, else cpu_gnt.
//  Handshake:
//   - Masters hold req/we/addr/wdata stable until gnt. The arbiter does not latch requests.
//   - A request is consumed in its gnt cycle.
//  Memory mux:
//   - mem_addr/mem_wdata come from the granted master (0 when none).
//   - mem_rd = gnt & ~we; mem_wr = gnt & we. Writes are single-cycle with no response.
//  Read return:
//   - rd_owner register <= {CPU,DMA,NONE} from the granted read.
//   - Next cycle: the matching rvalid=1 and rdata=mem_rdata.
//   - Back-to-back grants are fully pipelined; a return and a new grant may coincide.
//  wait_cnt (0..MAX_WAIT), updated each clk:
//   - dma_req & cpu_gnt: wait_cnt+1 (saturates at MAX_WAIT).
//   - dma_gnt or ~dma_req: wait_cnt <= 0.
//  Owner FSM (last grant holder, used for debug and the rd_owner mux):
//   - IDLE/CPU/DMA; next = CPU if cpu_gnt, DMA if dma_gnt, else IDLE.
//   - All transitions are legal every cycle.
//  Boundaries:
//   - MAX_WAIT=1: contended grants strictly alternate.
//   - cpu_stall is never asserted without cpu_req.
//   - Simultaneous writes: the loser's write is not performed and is retried by the master.
// STRUCTURE
//  Package mem_arb_pkg: owner_t enum {OWN_IDLE, OWN_CPU, OWN_DMA}; RD_NONE/RD_CPU/RD_DMA codes.
//  Sub-module arb_wait_counter: saturating counter with clear and at_max flag.
//  Grant, mux and read-return logic stay in data_mem_arbiter.
// TESTING
//  1 CPU-only reads addr 0x10,0x14 back-to-back, RAM returns A,B
//    -> cpu_gnt both cycles, cpu_stall=0; cpu_rvalid with rdata A then B, one cycle later each.
//  2 DMA-only write addr 0x20 data 0xDEADBEEF
//    -> dma_gnt=1, mem_wr=1, mem_addr=0x20; no rvalid; RAM holds 0xDEADBEEF.
//  3 Both request continuously, MAX_WAIT=4
//    -> grant pattern C,C,C,C,D repeating; cpu_stall=1 exactly on the D cycles.
//  4 Both request, CPU read granted while DMA waits; next cycle DMA forced
//    -> cpu_rvalid and dma_gnt in the same cycle, data not crossed.
//  5 Granted CPU read, reset pulsed low before the next edge
//    -> cpu_rvalid stays 0, all outputs 0; FSM IDLE, wait_cnt 0 after release.
//  6 dma_req drops with wait_cnt=3, then reasserts with cpu_req
//    -> counter restarted at 0; CPU granted the next 4 contended cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner states and read-return codes shared by the data memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} owner_t;
  typedef logic [1:0] rd_owner_t;
  localparam rd_owner_t RD_NONE = 2'd0;
  localparam rd_owner_t RD_CPU  = 2'd1;
  localparam rd_owner_t RD_DMA  = 2'd2;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive cycles DMA lost arbitration.
module arb_wait_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX_V) ? cnt_q + 1'b1 : cnt_q;
  assign at_max = cnt_q == MAX_V;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the CPU MEM stage and a DMA master,
// CPU first, with DMA forced a grant after MAX_WAIT consecutive lost contended cycles.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  owner_t    owner_q, owner_d;
  logic      rd_pend_q, rd_pend_d;
  rd_owner_t rd_owner;
  logic      at_max;
  arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (dma_req & cpu_gnt),
    .clr    (dma_gnt | ~dma_req),
    .at_max (at_max)
  );
  // Grants are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    cpu_gnt    = reset & cpu_req & ~(dma_req & at_max);
    dma_gnt    = reset & dma_req & ~(cpu_req & ~at_max);
    cpu_stall  = reset & cpu_req & ~cpu_gnt;
    mem_rd     = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    mem_wr     = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    mem_addr   = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
    mem_wdata  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    owner_d    = cpu_gnt ? OWN_CPU : dma_gnt ? OWN_DMA : OWN_IDLE;
    rd_pend_d  = mem_rd;
    rd_owner   = !rd_pend_q ? RD_NONE : owner_q == OWN_CPU ? RD_CPU : RD_DMA;
    cpu_rvalid = rd_owner == RD_CPU;
    dma_rvalid = rd_owner == RD_DMA;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q   <= OWN_IDLE;
      rd_pend_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random stimulus checked against a behavioural arbitration model.
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_rd, mem_wr;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [64];
  logic [DW-1:0] ref_mem [64];
  int npass = 0, ntot = 0;
  int wait_n = 0;
  bit pc = 0, pd = 0;
  logic [DW-1:0] pc_data = '0, pd_data = '0;
  bit obs_cg, obs_dg, obs_crv;
  logic [DW-1:0] obs_crd;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return {16'hC0DE, 8'(i), 8'(i * 7 + 3)};
  endfunction

  always @(posedge clk) begin
    if (!reset) for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    else if (mem_wr) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem_rd ? ram[mem_addr[7:2]] : $urandom();
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wait_n = 0;
    pc = 0;
    pd = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic cyc();
    bit eg_c, eg_d;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    @(negedge clk);
    eg_d = dma_req && (!cpu_req || wait_n == MW);
    eg_c = cpu_req && !eg_d;
    ea = eg_c ? cpu_addr : eg_d ? dma_addr : '0;
    ew = eg_c ? cpu_wdata : eg_d ? dma_wdata : '0;
    chk("cpu_gnt", 64'(cpu_gnt), 64'(eg_c));
    chk("dma_gnt", 64'(dma_gnt), 64'(eg_d));
    chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !eg_c));
    chk("mem_rd", 64'(mem_rd), 64'((eg_c && !cpu_we) || (eg_d && !dma_we)));
    chk("mem_wr", 64'(mem_wr), 64'((eg_c && cpu_we) || (eg_d && dma_we)));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wdata", 64'(mem_wdata), 64'(ew));
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(pc));
    chk("cpu_rdata", 64'(cpu_rdata), pc ? 64'(pc_data) : 64'd0);
    chk("dma_rvalid", 64'(dma_rvalid), 64'(pd));
    chk("dma_rdata", 64'(dma_rdata), pd ? 64'(pd_data) : 64'd0);
    obs_cg = cpu_gnt;
    obs_dg = dma_gnt;
    obs_crv = cpu_rvalid;
    obs_crd = cpu_rdata;
    wait_n = (dma_req && eg_c) ? (wait_n < MW ? wait_n + 1 : MW) : 0;
    pc = eg_c && !cpu_we;
    pd = eg_d && !dma_we;
    if (pc) pc_data = ref_mem[cpu_addr[7:2]];
    if (pd) pd_data = ref_mem[dma_addr[7:2]];
    if (eg_c && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
    if (eg_d && dma_we) ref_mem[dma_addr[7:2]] = dma_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1234;
    dma_req = 1; dma_we = 0; dma_addr = 32'h48;
    #1;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 0);
    chk("rst_dma_gnt", 64'(dma_gnt), 0);
    chk("rst_stall", 64'(cpu_stall), 0);
    chk("rst_mem_wr", 64'(mem_wr), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 0);
    @(posedge clk);
    #1;
    reset = 1;
    cpu_req = 0; dma_req = 0;
    cyc();
    // CPU-only back-to-back reads
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    cyc();
    chk("t1_gnt0", 64'(obs_cg), 1);
    cpu_addr = 32'h14;
    cyc();
    chk("t1_rv0", 64'(obs_crv), 1);
    chk("t1_data_a", 64'(obs_crd), 64'(init_word(4)));
    cpu_req = 0;
    cyc();
    chk("t1_data_b", 64'(obs_crd), 64'(init_word(5)));
    // DMA-only write
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hDEADBEEF;
    cyc();
    chk("t2_dgnt", 64'(obs_dg), 1);
    dma_req = 0;
    cyc();
    chk("t2_ram", 64'(ram[8]), 64'(32'hDEADBEEF));
    // continuous contention: C,C,C,C,D with return/grant overlap on D
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t3_dgnt", 64'(obs_dg), 64'(i % 5 == 4));
      if (i % 5 == 4) chk("t4_crv_with_dgnt", 64'(obs_crv), 1);
    end
    cpu_req = 0; dma_req = 0;
    cyc();
    // granted CPU read killed by reset before its return
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h18;
    @(negedge clk);
    chk("t5_gnt", 64'(cpu_gnt), 1);
    #3;
    reset = 0;
    #1;
    chk("t5_gnt_rst", 64'(cpu_gnt), 0);
    chk("t5_stall_rst", 64'(cpu_stall), 0);
    chk("t5_mem_rd_rst", 64'(mem_rd), 0);
    chk("t5_addr_rst", 64'(mem_addr), 0);
    @(posedge clk);
    #1;
    chk("t5_rvalid", 64'(cpu_rvalid), 0);
    chk("t5_rdata", 64'(cpu_rdata), 0);
    reset = 1;
    model_reset();
    cpu_req = 0;
    cyc();
    // wait count restarts after DMA drops its request
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h5555AAAA;
    dma_req = 1; dma_we = 1; dma_addr = 32'h34; dma_wdata = 32'h0F0F0F0F;
    repeat (3) cyc();
    dma_req = 0;
    cyc();
    dma_req = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_cgnt", 64'(obs_cg), 64'(i < 4));
    end
    cpu_req = 0; dma_req = 0;
    cyc();
    // random traffic; masters hold a request until granted
    for (int n = 0; n < 400; n++) begin
      if (!cpu_req || obs_cg) begin
        cpu_req = $urandom_range(0, 3) != 0;
        cpu_we = $urandom_range(0, 1) != 0;
        cpu_addr = {24'd0, 6'($urandom()), 2'b00};
        cpu_wdata = $urandom();
      end
      if (!dma_req || obs_dg) begin
        dma_req = $urandom_range(0, 2) != 0;
        dma_we = $urandom_range(0, 1) != 0;
        dma_addr = {24'd0, 6'($urandom()), 2'b00};
        dma_wdata = $urandom();
      end
      cyc();
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
